// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } fetch_state_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;
  localparam int unsigned WORD_BYTES = 4;

  function automatic logic is_syscall(input logic [31:0] word);
    return (word[31:26] == OPC_RTYPE) && (word[5:0] == FUNCT_SYSCALL);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO holding {instruction, pc} pairs between fetch and decode.
module fetch_queue #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] entry_q [2];
  logic             rd_q;
  logic             wr_q;
  logic [1:0]       count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      count_q    <= 2'd0;
    end else if (flush) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        entry_q[wr_q] <= din;
        wr_q          <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      // Simultaneous push and pop leaves occupancy unchanged, including when full.
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  assign count = count_q;
  assign head  = entry_q[rd_q];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, reads instruction memory and feeds decode through a
// 2-entry queue; handles start, redirect, SYSCALL halt and out-of-range fault.
module fetch_sequencer
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  // 33 bits so MEM_WORDS*4 = 2^32 still compares correctly.
  localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS * WORD_BYTES);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  count_q, count_d;

  logic         q_push, q_pop, q_flush;
  logic [1:0]   q_count;
  logic [63:0]  q_head;
  logic         dec_take;
  logic         push_ok;
  logic         pc_oob;

  fetch_queue #(
    .WIDTH(64)
  ) u_queue (
    .clk  (clk),
    .rst_n(rst_n),
    .push (q_push),
    .pop  (q_pop),
    .flush(q_flush),
    .din  ({imem_data, pc_q}),
    .count(q_count),
    .head (q_head)
  );

  assign instr_valid = (q_count != 2'd0);
  assign dec_take    = instr_valid & instr_ready;
  assign push_ok     = (q_count < 2'd2) | dec_take;
  assign pc_oob      = ({1'b0, pc_q} >= PC_LIMIT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    count_d = count_q;
    q_push  = 1'b0;
    q_pop   = dec_take;
    q_flush = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect) pc_d = {redirect_pc[31:2], 2'b00};
        if (start) state_d = RUN;
      end
      RUN: begin
        if (redirect) begin
          // Flush wins over any handshake decode sees this cycle.
          q_flush = 1'b1;
          q_pop   = 1'b0;
          pc_d    = {redirect_pc[31:2], 2'b00};
        end else if (push_ok) begin
          if (pc_oob) begin
            fault_d = 1'b1;
            state_d = HALTED;
          end else begin
            q_push  = 1'b1;
            pc_d    = pc_q + 32'(WORD_BYTES);
            count_d = count_q + 32'd1;
            if (is_syscall(imem_data)) state_d = HALTED;
          end
        end
      end
      HALTED: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      fault_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr_out   = instr_valid ? q_head[63:32] : 32'd0;
  assign instr_pc    = instr_valid ? q_head[31:0] : 32'd0;
  assign halted      = (state_q == HALTED);
  assign fault       = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a behavioural instruction memory.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [256];
  int checks;
  int errors;

  fetch_sequencer #(
    .RESET_PC (32'h0000_0000),
    .MEM_WORDS(256)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc),
    .halted     (halted),
    .fault      (fault),
    .fetch_count(fetch_count)
  );

  assign imem_data = (imem_addr < 32'd1024) ? mem[imem_addr[9:2]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Non-SYSCALL filler (addiu opcode) tagged with the word index.
  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h2400_0000 | 32'(i);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    start       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    fill_mem();
    rst_n = 1'b0; start = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    #2;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", instr_valid); end
    checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr got %0h exp 0", instr_out); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %0h exp 0", instr_pc); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %0h exp 0", imem_addr); end
    checks++; if ({halted, fault} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {halted, fault}); end
    checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count got %0d exp 0", fetch_count); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    fill_mem();
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    mem[4] = 32'h0000_000C;
    do_reset();
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i) || instr_out !== ((i == 4) ? 32'hC : 32'h0)) begin
        errors++;
        $display("FAIL seq_head%0d got v=%0b pc=%0h ins=%0h exp v=1 pc=%0h", i, instr_valid, instr_pc,
                 instr_out, 4 * i);
      end
    end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL seq_halted got %0b exp 1", halted); end
    checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL seq_count got %0d exp 5", fetch_count); end
    tick();
    checks++;
    if (instr_valid !== 1'b0 || fetch_count !== 32'd5 || imem_addr !== 32'h14 || fault !== 1'b0) begin
      errors++;
      $display("FAIL seq_after got v=%0b cnt=%0d addr=%0h f=%0b exp v=0 cnt=5 addr=14 f=0",
               instr_valid, fetch_count, imem_addr, fault);
    end
  endtask

  task automatic test_stall();
    fill_mem();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checks++;
    if (instr_pc !== 32'h0 || imem_addr !== 32'h8 || fetch_count !== 32'd2) begin
      errors++;
      $display("FAIL stall_hold got pc=%0h addr=%0h cnt=%0d exp pc=0 addr=8 cnt=2",
               instr_pc, imem_addr, fetch_count);
    end
    instr_ready = 1'b1;
    tick();
    checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL stall_second got %0h exp 4", instr_pc); end
    tick();
    checks++;
    if (instr_pc !== 32'h8 || instr_out !== 32'h2400_0002) begin
      errors++;
      $display("FAIL stall_third got pc=%0h ins=%0h exp pc=8 ins=24000002", instr_pc, instr_out);
    end
  endtask

  task automatic test_redirect();
    fill_mem();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h10; start = 1'b1;
    tick();
    redirect = 1'b0; start = 1'b0;
    tick();
    tick();
    checks++;
    if (instr_pc !== 32'h10 || imem_addr !== 32'h18) begin
      errors++;
      $display("FAIL redir_full got pc=%0h addr=%0h exp pc=10 addr=18", instr_pc, imem_addr);
    end
    redirect = 1'b1; redirect_pc = 32'h43;
    tick();
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL redir_flush got v=%0b addr=%0h exp v=0 addr=40", instr_valid, imem_addr);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr_out !== 32'h2400_0010 || fetch_count !== 32'd3) begin
      errors++;
      $display("FAIL redir_resume got v=%0b pc=%0h ins=%0h cnt=%0d exp v=1 pc=40 ins=24000010 cnt=3",
               instr_valid, instr_pc, instr_out, fetch_count);
    end
  endtask

  task automatic test_fault();
    fill_mem();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h3F8;
    tick();
    redirect = 1'b0;
    tick();
    checks++;
    if (imem_addr !== 32'h3F8 || instr_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 32'd0) begin
      errors++;
      $display("FAIL fault_idle got addr=%0h v=%0b h=%0b cnt=%0d exp addr=3f8 v=0 h=0 cnt=0",
               imem_addr, instr_valid, halted, fetch_count);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (instr_pc !== 32'h3F8 || imem_addr !== 32'h400 || fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_pre got pc=%0h addr=%0h f=%0b exp pc=3f8 addr=400 f=0", instr_pc, imem_addr, fault);
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if (fault !== 1'b1 || halted !== 1'b1 || instr_pc !== 32'h3FC || fetch_count !== 32'd2) begin
      errors++;
      $display("FAIL fault_set got f=%0b h=%0b pc=%0h cnt=%0d exp f=1 h=1 pc=3fc cnt=2",
               fault, halted, instr_pc, fetch_count);
    end
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fault_drain got %0b exp 0", instr_valid); end
    redirect = 1'b1; redirect_pc = 32'h0; start = 1'b1;
    tick();
    redirect = 1'b0; start = 1'b0;
    tick();
    checks++;
    if (imem_addr !== 32'h400 || halted !== 1'b1 || fault !== 1'b1 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_ignore got addr=%0h h=%0b f=%0b v=%0b exp addr=400 h=1 f=1 v=0",
               imem_addr, halted, fault, instr_valid);
    end
  endtask

  task automatic test_reset_mid();
    fill_mem();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (instr_valid !== 1'b1 || fetch_count !== 32'd2) begin
      errors++;
      $display("FAIL mid_full got v=%0b cnt=%0d exp v=1 cnt=2", instr_valid, fetch_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h0 || fetch_count !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset got v=%0b addr=%0h cnt=%0d exp v=0 addr=0 cnt=0",
               instr_valid, imem_addr, fetch_count);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    fill_mem();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (i + 1)) || imem_addr !== instr_pc + 32'd8 ||
          instr_out !== (32'h2400_0000 | 32'(i + 1))) begin
        errors++;
        $display("FAIL b2b_%0d got v=%0b pc=%0h addr=%0h ins=%0h exp pc=%0h addr=%0h", i, instr_valid,
                 instr_pc, imem_addr, instr_out, 4 * (i + 1), 4 * (i + 1) + 8);
      end
    end
    checks++; if (fetch_count !== 32'd8) begin errors++; $display("FAIL b2b_count got %0d exp 8", fetch_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_fault();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
